hi_simulate_gen: RTL

- Parametrised next-generation HF tag simulator. Single clock domain (13.56 MHz carrier).
- Configurable ADC hysteresis comparator. Field-presence detector.
- SSP bitstream interface with programmable frame length. Synchronised TX bit capture.
- Mode-selectable load modulation, gated by a LISTEN/MODULATE state machine so the antenna is never modulated without a reader field.
- Sits between the ADC / power-driver pins and the ARM SSP port.

---
 rtl/hi_simulate_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hi_simulate_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hi_simulate_gen : HF tag simulator; ADC hysteresis, field detect, SSP    |
// |                   framing and field-gated load modulation.               |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module hi_simulate_gen #(
  parameter int         DIV_W             = 11,
  parameter int         FRAME_BITS        = 8,
  parameter logic [7:0] HYST_HI           = 8'hE0,
  parameter logic [7:0] HYST_LO           = 8'h20,
  parameter int         FIELD_LOSS_CYCLES = 256
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic [7:0] adc_d,
  input  logic [2:0] mod_type,
  input  logic       ssp_dout,
  output logic       adc_clk,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  output logic       pwr_oe1,
  output logic       pwr_oe2,
  output logic       pwr_oe3,
  output logic       pwr_oe4,
  output logic       pwr_hi,
  output logic       pwr_lo,
  output logic       field_present,
  output logic       dbg
);

  localparam int c_fc_w = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int c_lc_w = $clog2(FIELD_LOSS_CYCLES + 1);
  localparam logic [c_lc_w-1:0] c_loss_cnt = c_lc_w'(FIELD_LOSS_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LISTEN   = 2'd1,
    ST_MODULATE = 2'd2
  } state_e;

  logic [DIV_W-1:0]  div_q, div_d, div_nxt;
  logic              ssp_clk_q, ssp_clk_d;
  logic [2:0]        mode_q, mode_d;
  logic [c_fc_w-1:0] frame_cnt_q, frame_cnt_d;
  logic              tx_bit_q, tx_bit_d;
  logic              hyst_q, hyst_d;
  logic              ssp_din_q, ssp_din_d;
  logic              ssp_frame_q, ssp_frame_d;
  logic [c_lc_w-1:0] low_cnt_q, low_cnt_d;
  logic              field_q, field_d;
  state_e            state_q, state_d;
  logic              carrier_q, carrier_d;
  logic              pwr_q, pwr_d;
  logic              mode_mod;
  logic              adc_hi, adc_lo;

  assign div_nxt  = div_q + 1'b1;
  assign adc_hi   = (adc_d >= HYST_HI);
  assign adc_lo   = (adc_d <= HYST_LO);
  assign mode_mod = (mode_q == 3'b001) || (mode_q == 3'b010) ||
                    (mode_q == 3'b100) || (mode_q == 3'b101);

  always_comb begin
    div_d       = div_q;
    ssp_clk_d   = ssp_clk_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    tx_bit_d    = tx_bit_q;
    ssp_din_d   = ssp_din_q;
    ssp_frame_d = ssp_frame_q;

    // A new mode restarts the bit clock so the next frame begins aligned
    if (mod_type != mode_q) begin
      div_d       = '0;
      ssp_clk_d   = 1'b0;
      frame_cnt_d = '0;
      tx_bit_d    = 1'b0;
      mode_d      = mod_type;
    end else begin
      div_d = div_nxt;
      case (mode_q)
        3'b101:  ssp_clk_d = div_nxt[7];
        3'b010:  ssp_clk_d = div_nxt[5];
        default: ssp_clk_d = div_nxt[4];
      endcase
      if (!ssp_clk_q && ssp_clk_d) begin
        ssp_din_d   = hyst_q;
        ssp_frame_d = (frame_cnt_q == '0);
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      if (ssp_clk_q && !ssp_clk_d) begin
        tx_bit_d = ssp_dout;
      end
    end
  end

  always_comb begin
    hyst_d = hyst_q;
    if (adc_hi) begin
      hyst_d = 1'b1;
    end else if (adc_lo) begin
      hyst_d = 1'b0;
    end

    low_cnt_d = '0;
    if (adc_lo) begin
      low_cnt_d = (low_cnt_q == c_loss_cnt) ? low_cnt_q : low_cnt_q + 1'b1;
    end

    field_d = field_q;
    if (adc_hi) begin
      field_d = 1'b1;
    end else if (low_cnt_d == c_loss_cnt) begin
      field_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!field_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_LISTEN;
        ST_LISTEN:   state_d = mode_mod ? ST_MODULATE : ST_LISTEN;
        ST_MODULATE: state_d = mode_mod ? ST_MODULATE : ST_LISTEN;
        default:     state_d = ST_IDLE;
      endcase
    end

    case (mode_q)
      3'b001:         carrier_d = tx_bit_q ^ div_q[3];
      3'b010:         carrier_d = tx_bit_q & div_q[5];
      3'b100, 3'b101: carrier_d = tx_bit_q & div_q[4];
      default:        carrier_d = 1'b0;
    endcase

    // Gate with the next state so field loss silences the antenna promptly
    pwr_d = carrier_q & (state_d == ST_MODULATE);
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      ssp_clk_q   <= 1'b0;
      mode_q      <= 3'b000;
      frame_cnt_q <= '0;
      tx_bit_q    <= 1'b0;
      hyst_q      <= 1'b0;
      ssp_din_q   <= 1'b0;
      ssp_frame_q <= 1'b0;
      low_cnt_q   <= '0;
      field_q     <= 1'b0;
      state_q     <= ST_IDLE;
      carrier_q   <= 1'b0;
      pwr_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      ssp_clk_q   <= ssp_clk_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      tx_bit_q    <= tx_bit_d;
      hyst_q      <= hyst_d;
      ssp_din_q   <= ssp_din_d;
      ssp_frame_q <= ssp_frame_d;
      low_cnt_q   <= low_cnt_d;
      field_q     <= field_d;
      state_q     <= state_d;
      carrier_q   <= carrier_d;
      pwr_q       <= pwr_d;
    end
  end

  assign adc_clk       = ck_1356meg;
  assign ssp_clk       = ssp_clk_q;
  assign ssp_frame     = ssp_frame_q;
  assign ssp_din       = ssp_din_q;
  assign dbg           = ssp_din_q;
  assign field_present = field_q;
  assign pwr_oe1       = pwr_q;
  assign pwr_oe2       = pwr_q;
  assign pwr_oe4       = pwr_q;
  assign pwr_oe3       = 1'b0;
  assign pwr_hi        = 1'b0;
  assign pwr_lo        = 1'b0;

endmodule
`default_nettype wire
